// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation engine.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MUL,
    SQR,
    NEXT,
    DONE
  } state_e;

  localparam logic [1:0] KEY_E = 2'd0;
  localparam logic [1:0] KEY_D = 2'd1;
  localparam logic [1:0] KEY_N = 2'd2;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Start-to-done latency for valid operands, in clock cycles.
  function automatic int unsigned LAT(input int unsigned width, input int unsigned exp_w);
    return 3 + exp_w * (2 * (width + 1) + 1);
  endfunction

endpackage

// File: rtl/rsa_modmult.sv
// Interleaved shift-add modular multiplier: p = a*b mod n, one bit of a per
// cycle MSB first; requires b < n. One load cycle plus WIDTH iterate cycles.
module rsa_modmult
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] n_i,
  output logic             done_o,
  output logic [WIDTH-1:0] p_o
);

  localparam int unsigned RW = WIDTH + 2;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [RW-1:0]    sum_c, sub1_c, sub2_c;

  always_comb begin
    r_d    = r_q;
    a_d    = a_q;
    b_d    = b_q;
    n_d    = n_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    sum_c  = '0;
    sub1_c = '0;
    sub2_c = '0;
    if (start_i) begin
      r_d   = '0;
      a_d   = a_i;
      b_d   = b_i;
      n_d   = n_i;
      cnt_d = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      // 2r + b < 3n, so at most two conditional subtractions restore r < n.
      sum_c  = {1'b0, r_q, 1'b0} + (a_q[WIDTH-1] ? RW'(b_q) : RW'(0));
      sub1_c = (sum_c >= RW'(n_q)) ? sum_c - RW'(n_q) : sum_c;
      sub2_c = (sub1_c >= RW'(n_q)) ? sub1_c - RW'(n_q) : sub1_c;
      r_d    = WIDTH'(sub2_c);
      a_d    = {a_q[WIDTH-2:0], 1'b0};
      cnt_d  = cnt_q - CW'(1);
      done_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      a_q    <= a_d;
      b_q    <= b_d;
      n_q    <= n_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign p_o    = r_q;

endmodule

// File: rtl/rsa_modexp_core.sv
// Constant-time RSA modular exponentiation (right-to-left square-and-multiply)
// with programmable e/d/n key registers and a start/done handshake.
module rsa_modexp_core
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned EXP_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_we,
  input  logic [1:0]       key_sel,
  input  logic [WIDTH-1:0] key_data,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int unsigned    BCW      = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(EXP_W - 1);

  state_e           state_q, state_d;
  logic [EXP_W-1:0] ekey_q, ekey_d;
  logic [EXP_W-1:0] dkey_q, dkey_d;
  logic [WIDTH-1:0] nkey_q, nkey_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [BCW-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             kick_q, kick_d;
  logic             chk_err_q, chk_err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             mm_start_c;
  logic [WIDTH-1:0] mm_a_c;
  logic             mm_done;
  logic [WIDTH-1:0] mm_p;

  rsa_modmult #(
    .WIDTH(WIDTH)
  ) u_modmult (
    .clk    (clk),
    .rst_n  (rst),
    .start_i(mm_start_c),
    .a_i    (mm_a_c),
    .b_i    (base_q),
    .n_i    (nkey_q),
    .done_o (mm_done),
    .p_o    (mm_p)
  );

  always_comb begin
    state_d    = state_q;
    ekey_d     = ekey_q;
    dkey_d     = dkey_q;
    nkey_d     = nkey_q;
    exp_d      = exp_q;
    bit_d      = bit_q;
    base_d     = base_q;
    acc_d      = acc_q;
    kick_d     = 1'b0;
    chk_err_d  = chk_err_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    result_d   = result_q;
    mm_start_c = 1'b0;
    mm_a_c     = acc_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CHECK;
          busy_d  = 1'b1;
          base_d  = data_in;
          acc_d   = WIDTH'(1);
          exp_d   = (mode == MODE_DEC) ? dkey_q : ekey_q;
          bit_d   = '0;
        end else if (key_we) begin
          case (key_sel)
            KEY_E:   ekey_d = EXP_W'(key_data);
            KEY_D:   dkey_d = EXP_W'(key_data);
            KEY_N:   nkey_d = key_data;
            default: ;
          endcase
        end
      end
      CHECK: begin
        chk_err_d = (nkey_q < WIDTH'(2)) || (base_q >= nkey_q);
        if (chk_err_d) begin
          state_d = DONE;
        end else begin
          state_d = MUL;
          kick_d  = 1'b1;
        end
      end
      MUL: begin
        // First multiply is launched from the registered kick; the square is
        // launched on the same edge that retires the multiply.
        mm_start_c = kick_q;
        if (mm_done) begin
          acc_d      = exp_q[0] ? mm_p : acc_q;
          mm_start_c = 1'b1;
          mm_a_c     = base_q;
          state_d    = SQR;
        end
      end
      SQR: begin
        if (mm_done) begin
          base_d  = mm_p;
          state_d = NEXT;
        end
      end
      NEXT: begin
        exp_d = exp_q >> 1;
        bit_d = bit_q + BCW'(1);
        if (bit_q == LAST_BIT) begin
          state_d = DONE;
        end else begin
          mm_start_c = 1'b1;
          state_d    = MUL;
        end
      end
      DONE: begin
        state_d  = IDLE;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        err_d    = chk_err_q;
        result_d = chk_err_q ? '0 : acc_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ekey_q    <= '0;
      dkey_q    <= '0;
      nkey_q    <= '0;
      exp_q     <= '0;
      bit_q     <= '0;
      base_q    <= '0;
      acc_q     <= '0;
      kick_q    <= 1'b0;
      chk_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      ekey_q    <= ekey_d;
      dkey_q    <= dkey_d;
      nkey_q    <= nkey_d;
      exp_q     <= exp_d;
      bit_q     <= bit_d;
      base_q    <= base_d;
      acc_q     <= acc_d;
      kick_q    <= kick_d;
      chk_err_q <= chk_err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Scoreboard bench for rsa_modexp_core: expected results from a plain
// repeated-multiplication model, checked by an independent done monitor.
module tb_rsa_modexp_core;
  import rsa_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned EW = 8;

  typedef struct {
    logic [W-1:0]    res;
    logic            err;
    longint unsigned due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_we;
  logic [1:0]   key_sel;
  logic [W-1:0] key_data;
  logic         start;
  logic         mode;
  logic [W-1:0] data_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;

  exp_t            sb[$];
  longint unsigned cyc = 0;
  int              n_checks = 0;
  int              n_pass = 0;
  int unsigned     m_e = 0, m_d = 0, m_n = 0;

  rsa_modexp_core #(.WIDTH(W), .EXP_W(EW)) dut (
    .clk     (clk),
    .rst     (rst),
    .key_we  (key_we),
    .key_sel (key_sel),
    .key_data(key_data),
    .start   (start),
    .mode    (mode),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint unsigned act, input longint unsigned expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  function automatic longint unsigned ref_modexp(input longint unsigned b, input longint unsigned ex,
                                                 input longint unsigned m);
    longint unsigned r;
    r = 1 % m;
    for (longint unsigned k = 0; k < ex; k++) r = (r * b) % m;
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t x;
    if (rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(done), 0);
      end else begin
        x = sb.pop_front();
        check("result", 64'(result), 64'(x.res));
        check("err", 64'(err), 64'(x.err));
        check("latency_cycle", cyc, x.due);
        check("busy_low_at_done", 64'(busy), 0);
      end
    end
  end

  task automatic write_key(input logic [1:0] sel, input int unsigned val);
    @(negedge clk);
    key_we = 1'b1; key_sel = sel; key_data = W'(val);
    @(negedge clk);
    key_we = 1'b0;
    case (sel)
      KEY_E:   m_e = val & ((1 << EW) - 1);
      KEY_D:   m_d = val & ((1 << EW) - 1);
      KEY_N:   m_n = val & ((1 << W) - 1);
      default: ;
    endcase
  endtask

  task automatic issue(input logic m, input logic [W-1:0] din, input bit with_kwe);
    exp_t x;
    longint unsigned ex;
    @(negedge clk);
    ex    = (m == MODE_DEC) ? 64'(m_d) : 64'(m_e);
    x.err = (m_n < 2) || (int'(din) >= int'(m_n));
    x.res = x.err ? '0 : W'(ref_modexp(64'(din), ex, 64'(m_n)));
    x.due = cyc + 1 + (x.err ? 64'(2) : 64'(LAT(W, EW)));
    start = 1'b1; mode = m; data_in = din;
    if (with_kwe) begin
      key_we = 1'b1; key_sel = KEY_N; key_data = W'(200);
    end
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0; key_we = 1'b0;
    check("busy_after_start", 64'(busy), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 64'(sb.size()), 0);
      sb.delete();
    end
  endtask

  initial begin
    logic [W-1:0] din;
    rst = 1'b0; key_we = 1'b0; key_sel = '0; key_data = '0;
    start = 1'b0; mode = MODE_ENC; data_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 0);
    check("reset_done", 64'(done), 0);
    check("reset_err", 64'(err), 0);
    check("reset_result", 64'(result), 0);
    rst = 1'b1;

    write_key(KEY_E, 7); write_key(KEY_N, 143); write_key(KEY_D, 103);
    issue(MODE_ENC, 8'd5, 0);  wait_idle();
    issue(MODE_DEC, 8'd47, 0); wait_idle();
    write_key(KEY_E, 0);
    issue(MODE_ENC, 8'd9, 0);  wait_idle();
    write_key(KEY_E, 7);
    issue(MODE_ENC, 8'd0, 0);  wait_idle();
    issue(MODE_ENC, 8'd150, 0); wait_idle();
    write_key(KEY_N, 1);
    issue(MODE_ENC, 8'd0, 0);  wait_idle();
    write_key(KEY_N, 143);
    write_key(2'd3, 99);
    issue(MODE_ENC, 8'd5, 0);  wait_idle();
    // Key write coincident with start must be dropped.
    issue(MODE_ENC, 8'd5, 1);  wait_idle();

    // Start and key write while busy must both be ignored.
    issue(MODE_ENC, 8'd5, 0);
    repeat (20) @(negedge clk);
    start = 1'b1; mode = MODE_DEC; data_in = 8'd7;
    key_we = 1'b1; key_sel = KEY_N; key_data = 8'd200;
    @(negedge clk);
    start = 1'b0; key_we = 1'b0;
    wait_idle();
    issue(MODE_ENC, 8'd5, 0);  wait_idle();

    for (int i = 0; i < 8; i++) begin
      write_key(KEY_N, $urandom_range(255, 2));
      write_key(KEY_E, $urandom_range(255, 0));
      write_key(KEY_D, $urandom_range(255, 0));
      if (i % 4 == 3) din = W'($urandom_range(255, m_n));
      else            din = W'($urandom_range(m_n - 1, 0));
      issue(1'($urandom_range(1, 0)), din, 0);
      wait_idle();
    end

    // Asynchronous reset mid-operation aborts without a done pulse.
    write_key(KEY_E, 7); write_key(KEY_N, 143);
    issue(MODE_ENC, 8'd5, 0); wait_idle();
    issue(MODE_ENC, 8'd5, 0);
    repeat (49) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 0);
    check("abort_result", 64'(result), 0);
    check("abort_done", 64'(done), 0);
    sb.delete();
    m_e = 0; m_d = 0; m_n = 0;
    repeat (3) @(negedge clk);
    check("abort_done_held", 64'(done), 0);
    rst = 1'b1;
    write_key(KEY_E, 7); write_key(KEY_N, 143);
    issue(MODE_ENC, 8'd5, 0); wait_idle();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
